// File: rtl/id_ex_pipe_reg_pkg.sv
// Shared RISC-V decode definitions for the ID/EX pipeline register: control word
// layout, ALU op encodings and the occupancy state type.
package id_ex_pipe_reg_pkg;

   localparam int DEF_CTRL_W = 8;
   localparam int REG_IDX_W  = 5;

   // Control word bit positions
   localparam int ALU_OP_LSB = 0;
   localparam int ALU_OP_MSB = 3;
   localparam int MEM_RD_BIT = 4;
   localparam int MEM_WR_BIT = 5;
   localparam int REG_WR_BIT = 6;
   localparam int WB_SEL_BIT = 7;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } occ_state_e;

endpackage

// File: rtl/id_ex_slot.sv
// Load-enabled payload register for one ID/EX entry with synchronous
// active-low clear.
module id_ex_slot #(
   parameter int N      = 32,
   parameter int CTRL_W = 8
) (
   input  logic              clk,
   input  logic              clr_n,
   input  logic              load,
   input  logic [N-1:0]      d_pc,
   input  logic [N-1:0]      d_opa,
   input  logic [N-1:0]      d_opb,
   input  logic [4:0]        d_rd,
   input  logic [CTRL_W-1:0] d_ctrl,
   output logic [N-1:0]      q_pc,
   output logic [N-1:0]      q_opa,
   output logic [N-1:0]      q_opb,
   output logic [4:0]        q_rd,
   output logic [CTRL_W-1:0] q_ctrl
);

   // Payload storage: clear wins over load
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         q_pc   <= '0;
         q_opa  <= '0;
         q_opb  <= '0;
         q_rd   <= 5'd0;
         q_ctrl <= '0;
      end else if (load) begin
         q_pc   <= d_pc;
         q_opa  <= d_opa;
         q_opb  <= d_opb;
         q_rd   <= d_rd;
         q_ctrl <= d_ctrl;
      end
   end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with valid/ready handshake and flush. Define
// ID_EX_SKID_EN for the two-slot skid build with a registered in_ready.
module id_ex_pipe_reg
   import id_ex_pipe_reg_pkg::*;
#(
   parameter int N      = 32,
   parameter int CTRL_W = DEF_CTRL_W
) (
   input  logic              CLK,
   input  logic              RSTn,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [N-1:0]      in_pc,
   input  logic [N-1:0]      in_opa,
   input  logic [N-1:0]      in_opb,
   input  logic [4:0]        in_rd,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [N-1:0]      out_pc,
   output logic [N-1:0]      out_opa,
   output logic [N-1:0]      out_opb,
   output logic [4:0]        out_rd,
   output logic [CTRL_W-1:0] out_ctrl
);

   occ_state_e        state_r, state_nxt_s;
   logic              valid_r;
   logic              accept_s, drain_s, main_load_s, clr_n_s;
   logic [N-1:0]      main_d_pc_s, main_d_opa_s, main_d_opb_s;
   logic [4:0]        main_d_rd_s;
   logic [CTRL_W-1:0] main_d_ctrl_s, main_ctrl_s;

   assign accept_s  = in_valid & in_ready & ~flush;
   assign drain_s   = valid_r & out_ready;
   assign clr_n_s   = RSTn & ~flush;
   assign out_valid = valid_r;
   // Bubbles carry an all-zero control word so no write side effects leak
   assign out_ctrl  = valid_r ? main_ctrl_s : {CTRL_W{1'b0}};

`ifdef ID_EX_SKID_EN
   logic              ready_r, skid_load_s, main_from_skid_s;
   logic [N-1:0]      skid_pc_s, skid_opa_s, skid_opb_s;
   logic [4:0]        skid_rd_s;
   logic [CTRL_W-1:0] skid_ctrl_s;

   assign in_ready = ready_r;
`else
   assign in_ready = ~valid_r | out_ready;
`endif

   // Occupancy next-state and slot load decisions
   always_comb begin
      state_nxt_s = state_r;
      main_load_s = 1'b0;
`ifdef ID_EX_SKID_EN
      skid_load_s      = 1'b0;
      main_from_skid_s = 1'b0;
`endif
      case (state_r)
         ST_EMPTY: begin
            if (accept_s) begin
               main_load_s = 1'b1;
               state_nxt_s = ST_ONE;
            end else begin
               state_nxt_s = ST_EMPTY;
            end
         end
         ST_ONE: begin
            if (accept_s && drain_s) begin
               main_load_s = 1'b1;
               state_nxt_s = ST_ONE;
            end else if (accept_s) begin
`ifdef ID_EX_SKID_EN
               skid_load_s = 1'b1;
               state_nxt_s = ST_TWO;
`else
               state_nxt_s = ST_ONE;
`endif
            end else if (drain_s) begin
               state_nxt_s = ST_EMPTY;
            end else begin
               state_nxt_s = ST_ONE;
            end
         end
         ST_TWO: begin
            if (drain_s) begin
               main_load_s = 1'b1;
`ifdef ID_EX_SKID_EN
               main_from_skid_s = 1'b1;
`endif
               state_nxt_s = ST_ONE;
            end else begin
               state_nxt_s = ST_TWO;
            end
         end
         default: state_nxt_s = ST_EMPTY;
      endcase
      if (flush) begin
         state_nxt_s = ST_EMPTY;
      end else begin
         state_nxt_s = state_nxt_s;
      end
   end

   // State, valid and (skid build) ready registers
   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         state_r <= ST_EMPTY;
         valid_r <= 1'b0;
`ifdef ID_EX_SKID_EN
         ready_r <= 1'b1;
`endif
      end else begin
         state_r <= state_nxt_s;
         valid_r <= (state_nxt_s != ST_EMPTY);
`ifdef ID_EX_SKID_EN
         ready_r <= (state_nxt_s != ST_TWO);
`endif
      end
   end

   // Main slot source: skid entry when draining from TWO, else Decode
   always_comb begin
`ifdef ID_EX_SKID_EN
      if (main_from_skid_s) begin
         main_d_pc_s   = skid_pc_s;
         main_d_opa_s  = skid_opa_s;
         main_d_opb_s  = skid_opb_s;
         main_d_rd_s   = skid_rd_s;
         main_d_ctrl_s = skid_ctrl_s;
      end else begin
         main_d_pc_s   = in_pc;
         main_d_opa_s  = in_opa;
         main_d_opb_s  = in_opb;
         main_d_rd_s   = in_rd;
         main_d_ctrl_s = in_ctrl;
      end
`else
      main_d_pc_s   = in_pc;
      main_d_opa_s  = in_opa;
      main_d_opb_s  = in_opb;
      main_d_rd_s   = in_rd;
      main_d_ctrl_s = in_ctrl;
`endif
   end

   id_ex_slot #(.N(N), .CTRL_W(CTRL_W)) u_main (
      .clk    (CLK),
      .clr_n  (clr_n_s),
      .load   (main_load_s),
      .d_pc   (main_d_pc_s),
      .d_opa  (main_d_opa_s),
      .d_opb  (main_d_opb_s),
      .d_rd   (main_d_rd_s),
      .d_ctrl (main_d_ctrl_s),
      .q_pc   (out_pc),
      .q_opa  (out_opa),
      .q_opb  (out_opb),
      .q_rd   (out_rd),
      .q_ctrl (main_ctrl_s)
   );

`ifdef ID_EX_SKID_EN
   id_ex_slot #(.N(N), .CTRL_W(CTRL_W)) u_skid (
      .clk    (CLK),
      .clr_n  (clr_n_s),
      .load   (skid_load_s),
      .d_pc   (in_pc),
      .d_opa  (in_opa),
      .d_opb  (in_opb),
      .d_rd   (in_rd),
      .d_ctrl (in_ctrl),
      .q_pc   (skid_pc_s),
      .q_opa  (skid_opa_s),
      .q_opb  (skid_opb_s),
      .q_rd   (skid_rd_s),
      .q_ctrl (skid_ctrl_s)
   );
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg: accepted beats are queued, a monitor
// checks every presented/drained beat and the handshake against a FIFO model.
module tb_id_ex_pipe_reg;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] opa;
      logic [31:0] opb;
      logic [4:0]  rd;
      logic [7:0]  ctrl;
   } beat_t;

   logic        clk = 1'b0;
   logic        rstn, flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_pc, in_opa, in_opb, out_pc, out_opa, out_opb;
   logic [4:0]  in_rd, out_rd;
   logic [7:0]  in_ctrl, out_ctrl;

   beat_t q[$];
   int    n_checks = 0;
   int    n_errors = 0;
   bit    started  = 1'b0;
   bit    exp_ready = 1'b1;

   always #5 clk = ~clk;

   id_ex_pipe_reg #(.N(32), .CTRL_W(8)) dut (
      .CLK(clk), .RSTn(rstn), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_opa(in_opa), .in_opb(in_opb), .in_rd(in_rd), .in_ctrl(in_ctrl),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_opa(out_opa), .out_opb(out_opb), .out_rd(out_rd), .out_ctrl(out_ctrl)
   );

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Monitor: compares outputs with the model, pops drained beats, clears on flush/reset
   always @(negedge clk) begin
      #1;
      if (started) begin
`ifdef ID_EX_SKID_EN
         exp_ready = (q.size() < 2);
`else
         exp_ready = (q.size() == 0) || out_ready;
`endif
         check("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
         check("in_ready", {63'd0, in_ready}, {63'd0, exp_ready});
         if (q.size() > 0) begin
            check("out_pc", {32'd0, out_pc}, {32'd0, q[0].pc});
            check("out_opa", {32'd0, out_opa}, {32'd0, q[0].opa});
            check("out_opb", {32'd0, out_opb}, {32'd0, q[0].opb});
            check("out_rd", {59'd0, out_rd}, {59'd0, q[0].rd});
            check("out_ctrl", {56'd0, out_ctrl}, {56'd0, q[0].ctrl});
            if (out_ready) void'(q.pop_front());
         end else begin
            check("bubble_ctrl", {56'd0, out_ctrl}, 64'd0);
         end
      end
      #2;
      if (!rstn || flush) q.delete();
   end

   // One cycle of stimulus; reports whether the model counts the beat as accepted
   task automatic step(input bit v, input logic [31:0] pc, input logic [7:0] ctrl,
                       input bit ordy, input bit fl, input bit rst, output bit acc);
      beat_t b;
      @(negedge clk);
      in_valid  = v;
      in_pc     = pc;
      in_opa    = $urandom;
      in_opb    = $urandom;
      in_rd     = 5'($urandom_range(0, 31));
      in_ctrl   = ctrl;
      out_ready = ordy;
      flush     = fl;
      rstn      = ~rst;
      #2;
      acc = v && exp_ready && rstn && !flush;
      if (acc) begin
         b.pc = in_pc; b.opa = in_opa; b.opb = in_opb; b.rd = in_rd; b.ctrl = in_ctrl;
         q.push_back(b);
      end
   endtask

   initial begin
      bit          acc;
      bit          pend;
      logic [31:0] cur_pc;
      logic [7:0]  cur_ctrl;
      rstn = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
      in_pc = 32'd0; in_opa = 32'd0; in_opb = 32'd0; in_rd = 5'd0; in_ctrl = 8'hFF;
      @(posedge clk);
      started = 1'b1;
      // Reset with in_valid held high
      step(1'b1, 32'h44, 8'hFF, 1'b0, 1'b0, 1'b1, acc);
      step(1'b1, 32'h48, 8'hFF, 1'b0, 1'b0, 1'b1, acc);
      step(1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 1'b0, acc);
      #1;
      check("rst_out_pc", {32'd0, out_pc}, 64'd0);
      check("rst_out_rd", {59'd0, out_rd}, 64'd0);
      // Stream of four beats, out_ready high
      for (int i = 0; i < 4; i++) step(1'b1, 32'(i * 4), 8'h41, 1'b1, 1'b0, 1'b0, acc);
      step(1'b0, 32'h0, 8'h00, 1'b1, 1'b0, 1'b0, acc);
      step(1'b0, 32'h0, 8'h00, 1'b1, 1'b0, 1'b0, acc);
      // Back-pressure: 0x10, 0x14, 0x18 held, then release holding unaccepted beat
      step(1'b1, 32'h10, 8'h52, 1'b0, 1'b0, 1'b0, acc);
      step(1'b1, 32'h14, 8'h53, 1'b0, 1'b0, 1'b0, acc);
      step(1'b1, 32'h18, 8'h54, 1'b0, 1'b0, 1'b0, acc);
      step(1'b1, 32'h18, 8'h54, 1'b0, 1'b0, 1'b0, acc);
      pend = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step(pend, 32'h18, 8'h54, 1'b1, 1'b0, 1'b0, acc);
         if (acc) pend = 1'b0;
      end
      // Flush from a full register with an incoming beat 0x20
      step(1'b1, 32'h30, 8'h61, 1'b0, 1'b0, 1'b0, acc);
      step(1'b1, 32'h34, 8'h62, 1'b0, 1'b0, 1'b0, acc);
      step(1'b1, 32'h20, 8'h63, 1'b0, 1'b1, 1'b0, acc);
      step(1'b0, 32'h0, 8'h00, 1'b1, 1'b0, 1'b0, acc);
      step(1'b0, 32'h0, 8'h00, 1'b1, 1'b0, 1'b0, acc);
      // Bubble: all-ones control then idle
      step(1'b1, 32'h40, 8'hFF, 1'b1, 1'b0, 1'b0, acc);
      step(1'b0, 32'h0, 8'hFF, 1'b1, 1'b0, 1'b0, acc);
      step(1'b0, 32'h0, 8'hFF, 1'b1, 1'b0, 1'b0, acc);
      // Macro-off style: one occupied, toggle out_ready
      step(1'b1, 32'h50, 8'h71, 1'b0, 1'b0, 1'b0, acc);
      step(1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 1'b0, acc);
      step(1'b0, 32'h0, 8'h00, 1'b1, 1'b0, 1'b0, acc);
      // Randomized traffic with a legal hold-until-accepted driver
      pend = 1'b0; cur_pc = 32'h100; cur_ctrl = 8'h00;
      for (int i = 0; i < 400; i++) begin
         if (!pend && ($urandom_range(0, 3) != 0)) begin
            pend = 1'b1;
            cur_pc = cur_pc + 32'd4;
            cur_ctrl = 8'($urandom);
         end
         step(pend, cur_pc, cur_ctrl, ($urandom_range(0, 2) != 0),
              ($urandom_range(0, 19) == 0), ($urandom_range(0, 49) == 0), acc);
         if (acc || flush || !rstn) pend = 1'b0;
      end
      step(1'b0, 32'h0, 8'h00, 1'b1, 1'b0, 1'b0, acc);
      step(1'b0, 32'h0, 8'h00, 1'b1, 1'b0, 1'b0, acc);
      step(1'b0, 32'h0, 8'h00, 1'b1, 1'b0, 1'b0, acc);
      @(negedge clk);
      #4;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time bound");
      $fatal(1);
   end

endmodule
